// File: rtl/pwm_slew.sv
// Slew-rate limiter for the pwm duty input: walks the output toward a latched
// target by a fixed step, changing only on PWM period boundaries.
module pwm_slew #(
  parameter int period = 7,
  parameter int step   = 1,
  parameter int hold   = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [$clog2(period+1)-1:0]  target,
  input  logic                         target_stb,
  output logic [$clog2(period+1)-1:0]  out,
  output logic                         busy,
  output logic                         done
);

  localparam int W  = $clog2(period + 1);
  localparam int HW = (hold > 1) ? $clog2(hold) : 1;

  localparam logic [W-1:0]  P_MAX  = W'(period);
  localparam logic [W-1:0]  P_LAST = W'(period - 1);
  localparam logic [W-1:0]  STEP_W = W'(step);
  localparam logic [HW-1:0] H_LAST = HW'(hold - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_UP   = 2'd1,
    S_DOWN = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [W-1:0]  r_pcnt;
  logic [HW-1:0] r_hcnt;
  logic [W-1:0]  r_out;
  logic [W-1:0]  r_tgt;
  logic          r_busy;
  logic          r_done;

  logic          w_tick;
  logic          w_step_evt;
  logic [W-1:0]  w_tgt_clamp;
  logic [W:0]    w_sum;
  logic [W-1:0]  w_diff;
  logic [W-1:0]  w_up_val;
  logic [W-1:0]  w_dn_val;
  logic [W-1:0]  w_out_nxt;
  logic [W-1:0]  w_tgt_nxt;
  logic          w_done_nxt;
  logic          w_busy_nxt;

  assign w_tick      = (r_pcnt == P_LAST);
  assign w_step_evt  = w_tick && (r_hcnt == H_LAST);
  assign w_tgt_clamp = (target > P_MAX) ? P_MAX : target;

  // Sum carries an extra bit so a step past the top can never wrap.
  assign w_sum    = {1'b0, r_out} + {1'b0, STEP_W};
  assign w_diff   = r_out - STEP_W;
  assign w_up_val = (w_sum > {1'b0, r_tgt}) ? r_tgt : w_sum[W-1:0];
  assign w_dn_val = ((r_out < STEP_W) || (w_diff < r_tgt)) ? r_tgt : w_diff;

  // Free-running period and hold counters; only reset clears them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pcnt <= {W{1'b0}};
      r_hcnt <= {HW{1'b0}};
    end else if (w_tick) begin
      r_pcnt <= {W{1'b0}};
      r_hcnt <= (r_hcnt == H_LAST) ? {HW{1'b0}} : (r_hcnt + HW'(1));
    end else begin
      r_pcnt <= r_pcnt + W'(1);
      r_hcnt <= r_hcnt;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_out   <= {W{1'b0}};
      r_tgt   <= {W{1'b0}};
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_out   <= w_out_nxt;
      r_tgt   <= w_tgt_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Next-state logic: a strobe wins over a coincident step event.
  always_comb begin
    w_state_nxt = r_state;
    w_out_nxt   = r_out;
    w_tgt_nxt   = r_tgt;
    w_done_nxt  = 1'b0;
    if (target_stb) begin
      w_tgt_nxt = w_tgt_clamp;
      if (w_tgt_clamp > r_out) begin
        w_state_nxt = S_UP;
      end else if (w_tgt_clamp < r_out) begin
        w_state_nxt = S_DOWN;
      end else begin
        w_state_nxt = S_IDLE;
        w_done_nxt  = 1'b1;
      end
    end else if (w_step_evt) begin
      case (r_state)
        S_UP: begin
          w_out_nxt = w_up_val;
          if (w_up_val == r_tgt) begin
            w_state_nxt = S_IDLE;
            w_done_nxt  = 1'b1;
          end else begin
            w_state_nxt = S_UP;
          end
        end
        S_DOWN: begin
          w_out_nxt = w_dn_val;
          if (w_dn_val == r_tgt) begin
            w_state_nxt = S_IDLE;
            w_done_nxt  = 1'b1;
          end else begin
            w_state_nxt = S_DOWN;
          end
        end
        S_IDLE: begin
          w_state_nxt = S_IDLE;
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end else begin
      w_state_nxt = r_state;
    end
    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  assign out  = r_out;
  assign busy = r_busy;
  assign done = r_done;

endmodule

// File: tb/tb_pwm_slew.sv
// Bench for pwm_slew: three parameterisations run side by side against an
// arithmetic reference model, plus fixed vectors for the ramp corner cases.
module tb_pwm_slew;

  logic       clk;
  logic       rst;
  logic [2:0] tg     [3];
  logic       stb    [3];
  logic [2:0] o_out  [3];
  logic       o_busy [3];
  logic       o_done [3];

  pwm_slew #(.period(7), .step(1), .hold(1)) u0 (
    .clk(clk), .rst(rst), .target(tg[0]), .target_stb(stb[0]),
    .out(o_out[0]), .busy(o_busy[0]), .done(o_done[0]));
  pwm_slew #(.period(5), .step(1), .hold(1)) u1 (
    .clk(clk), .rst(rst), .target(tg[1]), .target_stb(stb[1]),
    .out(o_out[1]), .busy(o_busy[1]), .done(o_done[1]));
  pwm_slew #(.period(7), .step(3), .hold(2)) u2 (
    .clk(clk), .rst(rst), .target(tg[2]), .target_stb(stb[2]),
    .out(o_out[2]), .busy(o_busy[2]), .done(o_done[2]));

  int PP [3] = '{7, 5, 7};
  int SS [3] = '{1, 1, 3};
  int HH [3] = '{1, 1, 2};

  int m_out  [3];
  int m_tgt  [3];
  int m_done [3];
  int m_cyc;
  int total;
  int bad;

  typedef struct {
    int e;
    int stb;
    int tg;
    int eo;
    int eb;
    int ed;
  } vec_t;
  vec_t vt[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // One clock: advance the model from the inputs present, clock, compare all.
  task automatic step_clk();
    for (int i = 0; i < 3; i++) begin
      int k;
      bit evt;
      k   = m_cyc;
      evt = ((k % PP[i]) == PP[i] - 1) && (((k / PP[i]) % HH[i]) == HH[i] - 1);
      if (stb[i]) begin
        m_tgt[i]  = (int'(tg[i]) > PP[i]) ? PP[i] : int'(tg[i]);
        m_done[i] = (m_tgt[i] == m_out[i]) ? 1 : 0;
      end else if (evt && (m_out[i] != m_tgt[i])) begin
        if (m_out[i] < m_tgt[i])
          m_out[i] = (m_out[i] + SS[i] > m_tgt[i]) ? m_tgt[i] : m_out[i] + SS[i];
        else
          m_out[i] = (m_out[i] - SS[i] < m_tgt[i]) ? m_tgt[i] : m_out[i] - SS[i];
        m_done[i] = (m_out[i] == m_tgt[i]) ? 1 : 0;
      end else begin
        m_done[i] = 0;
      end
    end
    @(posedge clk);
    #1;
    m_cyc++;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("u%0d out e%0d", i, m_cyc), int'(o_out[i]), m_out[i]);
      chk($sformatf("u%0d busy e%0d", i, m_cyc), int'(o_busy[i]),
          (m_out[i] != m_tgt[i]) ? 1 : 0);
      chk($sformatf("u%0d done e%0d", i, m_cyc), int'(o_done[i]), m_done[i]);
      stb[i] = 1'b0;
    end
  endtask

  task automatic run_to(input int n);
    while (m_cyc < n) step_clk();
  endtask

  // Asserts reset, checks the outputs clear without an edge, then releases.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("u%0d rst out", i), int'(o_out[i]), 0);
      chk($sformatf("u%0d rst busy", i), int'(o_busy[i]), 0);
      chk($sformatf("u%0d rst done", i), int'(o_done[i]), 0);
      m_out[i]  = 0;
      m_tgt[i]  = 0;
      m_done[i] = 0;
      stb[i]    = 1'b0;
      tg[i]     = 3'd0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst   = 1'b0;
    m_cyc = 0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    m_cyc = 0;
    for (int i = 0; i < 3; i++) begin
      stb[i] = 1'b0;
      tg[i]  = 3'd0;
    end
    rst = 1'b0;
    #2;
    do_reset();

    // Edge-indexed vectors for u0 (period 7, step 1): step events at 7,14,...
    vt.push_back('{1, 1, 3, 0, 1, 0});
    vt.push_back('{6, 0, 0, 0, 1, 0});
    vt.push_back('{7, 0, 0, 1, 1, 0});
    vt.push_back('{14, 0, 0, 2, 1, 0});
    vt.push_back('{20, 0, 0, 2, 1, 0});
    vt.push_back('{21, 0, 0, 3, 0, 1});
    vt.push_back('{22, 0, 0, 3, 0, 0});
    vt.push_back('{23, 1, 3, 3, 0, 1});
    vt.push_back('{24, 0, 0, 3, 0, 0});
    vt.push_back('{25, 1, 6, 3, 1, 0});
    vt.push_back('{28, 0, 0, 4, 1, 0});
    vt.push_back('{29, 1, 2, 4, 1, 0});
    vt.push_back('{35, 0, 0, 3, 1, 0});
    vt.push_back('{41, 0, 0, 3, 1, 0});
    vt.push_back('{42, 1, 5, 3, 1, 0});
    vt.push_back('{49, 0, 0, 4, 1, 0});
    vt.push_back('{56, 0, 0, 5, 0, 1});
    vt.push_back('{57, 0, 0, 5, 0, 0});
    vt.push_back('{58, 1, 2, 5, 1, 0});
    vt.push_back('{63, 0, 0, 4, 1, 0});
    vt.push_back('{70, 0, 0, 3, 1, 0});
    vt.push_back('{77, 0, 0, 2, 0, 1});
    vt.push_back('{78, 0, 0, 2, 0, 0});
    vt.push_back('{79, 1, 2, 2, 0, 1});
    vt.push_back('{80, 0, 0, 2, 0, 0});
    for (int r = 0; r < vt.size(); r++) begin
      run_to(vt[r].e - 1);
      if (vt[r].stb != 0) begin
        stb[0] = 1'b1;
        tg[0]  = 3'(vt[r].tg);
      end
      step_clk();
      chk($sformatf("vec%0d out", r), int'(o_out[0]), vt[r].eo);
      chk($sformatf("vec%0d busy", r), int'(o_busy[0]), vt[r].eb);
      chk($sformatf("vec%0d done", r), int'(o_done[0]), vt[r].ed);
    end

    // Clamp on u1 (period 5) and saturation on u2 (step 3, hold 2).
    do_reset();
    stb[1] = 1'b1; tg[1] = 3'd7;
    stb[2] = 1'b1; tg[2] = 3'd7;
    step_clk();
    chk("u1 clamp busy", int'(o_busy[1]), 1);
    run_to(13); chk("u2 e13", int'(o_out[2]), 0);
    run_to(14); chk("u2 e14", int'(o_out[2]), 3);
    run_to(24); chk("u1 e24", int'(o_out[1]), 4);
    run_to(25); chk("u1 end", int'(o_out[1]), 5);
    chk("u1 end done", int'(o_done[1]), 1);
    run_to(27); chk("u2 e27", int'(o_out[2]), 3);
    run_to(28); chk("u2 e28", int'(o_out[2]), 6);
    run_to(41); chk("u2 e41", int'(o_out[2]), 6);
    run_to(42); chk("u2 sat", int'(o_out[2]), 7);
    chk("u2 sat done", int'(o_done[2]), 1);
    run_to(60); chk("u1 hold", int'(o_out[1]), 5);

    // Reset mid-ramp at out=5, then nothing moves without a strobe.
    do_reset();
    stb[0] = 1'b1; tg[0] = 3'd6;
    step_clk();
    run_to(35);
    chk("u0 pre-rst out", int'(o_out[0]), 5);
    chk("u0 pre-rst busy", int'(o_busy[0]), 1);
    do_reset();
    run_to(20);
    chk("u0 post-rst out", int'(o_out[0]), 0);
    chk("u0 post-rst busy", int'(o_busy[0]), 0);

    // Random retargeting on all three instances.
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 3; i++) begin
        if ($urandom_range(0, 14) == 0) begin
          stb[i] = 1'b1;
          tg[i]  = 3'($urandom_range(0, 7));
        end
      end
      step_clk();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
